// File: rtl/usb_slavefifo_mc.sv
// rtl/usb_slavefifo_mc.sv - FX2 synchronous slave-FIFO controller, one OUT and one IN endpoint
module usb_slavefifo_mc #(
    parameter int                      DATA_NBIT    = 16,
    parameter int                      FIFOADR_NBIT = 2,
    parameter int                      PKT_WORDS    = 256,
    parameter int                      LEN_NBIT     = 9,
    parameter logic [FIFOADR_NBIT-1:0] RX_EP_ADDR   = 2'b00,
    parameter logic [FIFOADR_NBIT-1:0] TX_EP_ADDR   = 2'b10,
    parameter bit                      ZLP_EN       = 1'b1
) (
    input  logic                    ifclk,
    input  logic                    rst_n,
    input  logic                    f_empty,
    input  logic                    f_full,
    input  logic [DATA_NBIT-1:0]    rdata,
    output logic                    sloe,
    output logic                    slrd,
    output logic                    slwr,
    output logic                    pkend,
    output logic [FIFOADR_NBIT-1:0] fifoaddr,
    output logic                    wen,
    output logic [DATA_NBIT-1:0]    wdata,
    output logic                    rx_vd,
    output logic [DATA_NBIT-1:0]    rx_data,
    output logic                    rx_sop,
    output logic                    rx_eop,
    input  logic                    tx_req,
    input  logic [LEN_NBIT-1:0]     tx_len,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic [LEN_NBIT-1:0]     tx_addr,
    input  logic [DATA_NBIT-1:0]    tx_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_ADR, S_RX, S_RX_FLUSH, S_TX_ADR, S_TX, S_TX_PKEND, S_TX_TURN
    } state_t;

    localparam logic [LEN_NBIT-1:0] PKT_LEN = LEN_NBIT'(PKT_WORDS);

    state_t                state, state_nxt;
    logic                  tx_pend;
    logic [LEN_NBIT-1:0]   tx_len_q;
    logic [LEN_NBIT-1:0]   rd_cnt;
    logic [LEN_NBIT-1:0]   idx;
    logic                  last_was_tx;
    logic [DATA_NBIT-1:0]  hold;
    logic                  hold_vld;
    logic                  rx_first;
    logic                  tx_acc, rx_ok, tx_ok, pick_tx, tx_last;

    assign tx_acc  = tx_req && !tx_pend && (ZLP_EN || (tx_len != '0));
    assign rx_ok   = !f_empty;
    assign tx_ok   = tx_pend && !f_full;
    // On a tie the direction not served last wins
    assign pick_tx = tx_ok && (!rx_ok || !last_was_tx);

    assign slrd    = (state == S_RX) && !f_empty && (rd_cnt < PKT_LEN);
    assign slwr    = (state == S_TX) && !f_full && (idx < tx_len_q);
    assign tx_last = (idx == tx_len_q) || (slwr && ((idx + LEN_NBIT'(1)) == tx_len_q));

    // RAM has one cycle of latency, so request the word needed next cycle
    assign tx_addr = slwr ? idx + LEN_NBIT'(1) : idx;
    assign wdata   = (state == S_TX) ? tx_data : '0;
    assign tx_busy = tx_pend;

    always_comb begin
        state_nxt = state;
        sloe      = 1'b0;
        wen       = 1'b0;
        pkend     = 1'b0;
        tx_done   = 1'b0;
        fifoaddr  = RX_EP_ADDR;
        case (state)
            S_IDLE: begin
                if (pick_tx)    state_nxt = S_TX_ADR;
                else if (rx_ok) state_nxt = S_RX_ADR;
            end
            S_RX_ADR: begin
                sloe      = 1'b1;
                state_nxt = S_RX;
            end
            S_RX: begin
                sloe = 1'b1;
                if (f_empty || (rd_cnt == PKT_LEN)) state_nxt = S_RX_FLUSH;
            end
            S_RX_FLUSH: state_nxt = S_IDLE;
            S_TX_ADR: begin
                fifoaddr  = TX_EP_ADDR;
                wen       = 1'b1;
                state_nxt = S_TX;
            end
            S_TX: begin
                fifoaddr = TX_EP_ADDR;
                wen      = 1'b1;
                // A full packet is committed by the FX2 itself
                if (tx_last) state_nxt = (tx_len_q < PKT_LEN) ? S_TX_PKEND : S_TX_TURN;
            end
            S_TX_PKEND: begin
                fifoaddr  = TX_EP_ADDR;
                wen       = 1'b1;
                pkend     = 1'b1;
                state_nxt = S_TX_TURN;
            end
            S_TX_TURN: begin
                fifoaddr  = TX_EP_ADDR;
                tx_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ifclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tx_pend     <= 1'b0;
            tx_len_q    <= '0;
            rd_cnt      <= '0;
            idx         <= '0;
            last_was_tx <= 1'b1;
            hold        <= '0;
            hold_vld    <= 1'b0;
            rx_first    <= 1'b0;
            rx_vd       <= 1'b0;
            rx_data     <= '0;
            rx_sop      <= 1'b0;
            rx_eop      <= 1'b0;
        end else begin
            state  <= state_nxt;
            rx_vd  <= 1'b0;
            rx_sop <= 1'b0;
            rx_eop <= 1'b0;

            if (tx_acc) begin
                tx_pend  <= 1'b1;
                tx_len_q <= (tx_len > PKT_LEN) ? PKT_LEN : tx_len;
            end else if (state == S_TX_TURN) begin
                tx_pend <= 1'b0;
            end

            if (state == S_IDLE && state_nxt == S_TX_ADR) last_was_tx <= 1'b1;
            else if (state == S_IDLE && state_nxt == S_RX_ADR) last_was_tx <= 1'b0;

            case (state)
                S_RX_ADR: begin
                    rd_cnt   <= '0;
                    hold_vld <= 1'b0;
                    rx_first <= 1'b1;
                end
                S_RX: begin
                    // Hold one word back so the last word can carry rx_eop
                    if (slrd) begin
                        rd_cnt   <= rd_cnt + LEN_NBIT'(1);
                        hold     <= rdata;
                        hold_vld <= 1'b1;
                        if (hold_vld) begin
                            rx_vd    <= 1'b1;
                            rx_data  <= hold;
                            rx_sop   <= rx_first;
                            rx_first <= 1'b0;
                        end
                    end
                end
                S_RX_FLUSH: begin
                    if (hold_vld) begin
                        rx_vd   <= 1'b1;
                        rx_data <= hold;
                        rx_sop  <= rx_first;
                        rx_eop  <= 1'b1;
                    end
                    hold_vld <= 1'b0;
                    rx_first <= 1'b0;
                end
                S_TX_ADR:  idx <= '0;
                S_TX:      if (slwr) idx <= idx + LEN_NBIT'(1);
                S_TX_TURN: idx <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_slavefifo_mc.sv
// tb/tb_usb_slavefifo_mc.sv - self-checking bench for usb_slavefifo_mc
module tb_usb_slavefifo_mc;

    localparam int DW  = 16;
    localparam int LW  = 9;
    localparam int PKT = 256;

    logic          ifclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          f_empty = 1'b1;
    logic          f_full = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          sloe, slrd, slwr, pkend, wen, rx_vd, rx_sop, rx_eop, tx_busy, tx_done;
    logic [1:0]    fifoaddr;
    logic [DW-1:0] wdata, rx_data;
    logic          tx_req = 1'b0;
    logic [LW-1:0] tx_len = '0;
    logic [LW-1:0] tx_addr;
    logic [DW-1:0] tx_data = '0;

    logic          nz_req = 1'b0;
    logic [LW-1:0] nz_len = '0;
    logic          nz_sloe, nz_slrd, nz_slwr, nz_pkend, nz_wen, nz_rx_vd, nz_rx_sop, nz_rx_eop;
    logic          nz_tx_busy, nz_tx_done;
    logic [1:0]    nz_fifoaddr;
    logic [DW-1:0] nz_wdata, nz_rx_data;
    logic [LW-1:0] nz_tx_addr;

    always #10 ifclk = ~ifclk;

    usb_slavefifo_mc u_dut (
        .ifclk(ifclk), .rst_n(rst_n), .f_empty(f_empty), .f_full(f_full), .rdata(rdata),
        .sloe(sloe), .slrd(slrd), .slwr(slwr), .pkend(pkend), .fifoaddr(fifoaddr),
        .wen(wen), .wdata(wdata), .rx_vd(rx_vd), .rx_data(rx_data), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .tx_req(tx_req), .tx_len(tx_len), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_addr(tx_addr), .tx_data(tx_data)
    );

    usb_slavefifo_mc #(.ZLP_EN(1'b0)) u_nozlp (
        .ifclk(ifclk), .rst_n(rst_n), .f_empty(1'b1), .f_full(1'b0), .rdata('0),
        .sloe(nz_sloe), .slrd(nz_slrd), .slwr(nz_slwr), .pkend(nz_pkend), .fifoaddr(nz_fifoaddr),
        .wen(nz_wen), .wdata(nz_wdata), .rx_vd(nz_rx_vd), .rx_data(nz_rx_data), .rx_sop(nz_rx_sop),
        .rx_eop(nz_rx_eop), .tx_req(nz_req), .tx_len(nz_len), .tx_busy(nz_tx_busy),
        .tx_done(nz_tx_done), .tx_addr(nz_tx_addr), .tx_data('0)
    );

    typedef struct packed {logic [DW-1:0] d; logic sop; logic eop;} rxw_t;

    logic [DW-1:0] out_q[$];
    logic [DW-1:0] in_cap[$];
    rxw_t          rx_got[$];
    int            svc_log[$];
    logic [DW-1:0] ram [0:511];
    bit            rx_hold = 1'b0, full_hold = 1'b0;
    int            stall_at = -1, stall_rem = 0;
    int            pk_cnt = 0, done_cnt = 0, stall_wr = 0, slrd_cnt = 0;
    int            overlap = 0, addr_bad = 0, underrun = 0, nz_bad = 0;
    logic          sloe_d = 1'b0, wen_d = 1'b0;
    int            checks = 0, failures = 0;

    always @(posedge ifclk) tx_data <= ram[tx_addr];

    // FX2 side: pop OUT words on slrd, collect IN words on slwr, watch invariants
    always @(posedge ifclk) begin
        if (slrd) begin
            slrd_cnt++;
            if (out_q.size() == 0) underrun++;
            else void'(out_q.pop_front());
        end
        if (slwr) in_cap.push_back(wdata);
        if (pkend) pk_cnt++;
        if (tx_done) done_cnt++;
        if (slwr && f_full) stall_wr++;
        if (sloe && wen) overlap++;
        if ((slrd && fifoaddr != 2'b00) || ((slwr || pkend) && fifoaddr != 2'b10)) addr_bad++;
        if (rx_vd) rx_got.push_back({rx_data, rx_sop, rx_eop});
        if (sloe && !sloe_d) svc_log.push_back(0);
        if (wen && !wen_d) svc_log.push_back(1);
        sloe_d = sloe;
        wen_d  = wen;
        if (nz_sloe | nz_slrd | nz_slwr | nz_pkend | nz_wen | (|nz_wdata) | nz_rx_vd | (|nz_rx_data) |
            nz_rx_sop | nz_rx_eop | nz_tx_busy | nz_tx_done | (|nz_tx_addr) | (|nz_fifoaddr))
            nz_bad++;
    end

    always @(negedge ifclk) begin
        f_empty = rx_hold || (out_q.size() == 0);
        rdata   = (out_q.size() != 0) ? out_q[0] : '0;
        if (stall_rem > 0 && stall_at >= 0 && in_cap.size() >= stall_at) begin
            f_full = 1'b1;
            stall_rem--;
        end else begin
            f_full = full_hold;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        in_cap.delete(); rx_got.delete(); svc_log.delete();
        pk_cnt = 0; done_cnt = 0; stall_wr = 0; slrd_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge ifclk);
        rst_n = 1'b0; tx_req = 1'b0; rx_hold = 1'b0; full_hold = 1'b0; stall_rem = 0;
        out_q.delete();
        repeat (3) @(negedge ifclk);
        rst_n = 1'b1;
        @(negedge ifclk);
    endtask

    task automatic issue_tx(input int len);
        tx_len = LW'(len); tx_req = 1'b1;
        @(negedge ifclk);
        tx_req = 1'b0; tx_len = '0;
    endtask

    function automatic int frame_errs(output int nb);
        int err = 0, blen = 0;
        bit inb = 1'b0;
        nb = 0;
        foreach (rx_got[i]) begin
            if (rx_got[i].sop) begin
                if (inb) err++;
                inb = 1'b1; blen = 0; nb++;
            end else if (!inb) err++;
            blen++;
            if (blen > PKT) err++;
            if (rx_got[i].eop) inb = 1'b0;
        end
        if (inb) err++;
        return err;
    endfunction

    typedef struct {int len; int st_at; int st_n; int exp_words; int exp_pk;} txv_t;
    txv_t          tv[7];
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] w;
    int            n, mism, nb, exp_pk, exp_done, l, lc, base;
    logic [3:0]    sop_v, eop_v;

    initial begin
        tv[0] = '{5,   -1,  0, 5,   1};
        tv[1] = '{256, 100, 3, 256, 0};
        tv[2] = '{0,   -1,  0, 0,   1};
        tv[3] = '{300, -1,  0, 256, 0};
        tv[4] = '{1,   0,   2, 1,   1};
        tv[5] = '{255, 200, 5, 255, 1};
        tv[6] = '{17,  8,   1, 17,  1};
        for (int i = 0; i < 512; i++) ram[i] = '0;

        #5 rst_n = 1'b0;
        @(negedge ifclk);
        chk("rst_ctrl", int'({sloe, slrd, slwr, pkend, wen, rx_vd, rx_sop, rx_eop, tx_busy, tx_done}), 0);
        chk("rst_fifoaddr", int'(fifoaddr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_tx_addr", int'(tx_addr), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        repeat (2) @(negedge ifclk);
        rst_n = 1'b1;
        @(negedge ifclk);

        // Four-word OUT burst
        clear_logs();
        out_q.push_back(16'h1111); out_q.push_back(16'h2222);
        out_q.push_back(16'h3333); out_q.push_back(16'h4444);
        n = 0;
        while (rx_got.size() < 4 && n < 200) begin @(negedge ifclk); n++; end
        repeat (5) @(negedge ifclk);
        chk("rx4_count", rx_got.size(), 4);
        chk("rx4_slrd", slrd_cnt, 4);
        sop_v = '0; eop_v = '0;
        for (int i = 0; i < 4 && i < rx_got.size(); i++) begin
            chk("rx4_data", int'(rx_got[i].d), 16'h1111 * (i + 1));
            sop_v[i] = rx_got[i].sop;
            eop_v[i] = rx_got[i].eop;
        end
        chk("rx4_sop", int'(sop_v), 4'b0001);
        chk("rx4_eop", int'(eop_v), 4'b1000);

        // 300 words split at the packet size
        clear_logs(); exp_rx.delete();
        for (int i = 0; i < 300; i++) begin w = DW'($urandom); out_q.push_back(w); exp_rx.push_back(w); end
        n = 0;
        while (rx_got.size() < 300 && n < 2000) begin @(negedge ifclk); n++; end
        repeat (5) @(negedge ifclk);
        chk("rx300_count", rx_got.size(), 300);
        mism = 0;
        foreach (rx_got[i]) if (i < exp_rx.size() && rx_got[i].d !== exp_rx[i]) mism++;
        chk("rx300_data", mism, 0);
        chk("rx300_frame", frame_errs(nb), 0);
        chk("rx300_bursts", nb, 2);
        if (rx_got.size() >= 257) begin
            chk("rx300_eop255", int'(rx_got[255].eop), 1);
            chk("rx300_sop256", int'(rx_got[256].sop), 1);
        end

        // IN transfers from the vector table
        for (int k = 0; k < 7; k++) begin
            clear_logs();
            for (int i = 0; i < 512; i++) ram[i] = (k == 0) ? DW'(16'h00A0 + i) : DW'($urandom);
            stall_at = tv[k].st_at; stall_rem = tv[k].st_n;
            issue_tx(tv[k].len);
            chk($sformatf("tx%0d_busy", k), int'(tx_busy), 1);
            issue_tx(3);
            n = 0;
            while (done_cnt < 1 && n < 1500) begin @(negedge ifclk); n++; end
            repeat (8) @(negedge ifclk);
            chk($sformatf("tx%0d_words", k), in_cap.size(), tv[k].exp_words);
            mism = 0;
            foreach (in_cap[i]) if (in_cap[i] !== ram[i]) mism++;
            chk($sformatf("tx%0d_data", k), mism, 0);
            chk($sformatf("tx%0d_pkend", k), pk_cnt, tv[k].exp_pk);
            chk($sformatf("tx%0d_done", k), done_cnt, 1);
            chk($sformatf("tx%0d_stall_wr", k), stall_wr, 0);
            chk($sformatf("tx%0d_idle_busy", k), int'(tx_busy), 0);
        end
        stall_at = -1; stall_rem = 0;

        // Zero-length request with ZLP disabled
        nz_req = 1'b1; nz_len = '0;
        @(negedge ifclk);
        nz_req = 1'b0;
        chk("nozlp_busy", int'(nz_tx_busy), 0);
        repeat (6) @(negedge ifclk);
        chk("nozlp_busy_late", int'(nz_tx_busy), 0);

        // Both directions pending: RX, TX, RX
        do_reset();
        clear_logs(); exp_rx.delete();
        rx_hold = 1'b1; full_hold = 1'b1;
        for (int i = 0; i < 300; i++) begin w = DW'($urandom); out_q.push_back(w); exp_rx.push_back(w); end
        for (int i = 0; i < 512; i++) ram[i] = DW'($urandom);
        issue_tx(5);
        @(negedge ifclk);
        rx_hold = 1'b0; full_hold = 1'b0;
        n = 0;
        while ((done_cnt < 1 || rx_got.size() < 300) && n < 3000) begin @(negedge ifclk); n++; end
        repeat (5) @(negedge ifclk);
        chk("alt_nsvc", svc_log.size(), 3);
        if (svc_log.size() >= 3) chk("alt_order", svc_log[0] * 100 + svc_log[1] * 10 + svc_log[2], 10);
        chk("alt_rx_count", rx_got.size(), 300);
        chk("alt_tx_count", in_cap.size(), 5);
        mism = 0;
        foreach (in_cap[i]) if (in_cap[i] !== ram[i]) mism++;
        foreach (rx_got[i]) if (i < exp_rx.size() && rx_got[i].d !== exp_rx[i]) mism++;
        chk("alt_data", mism, 0);

        // Randomized traffic against the stream model
        clear_logs(); exp_rx.delete(); exp_tx.delete();
        exp_pk = 0; exp_done = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge ifclk);
            rx_hold   = ($urandom_range(0, 7) == 0);
            full_hold = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                n = $urandom_range(1, 40);
                repeat (n) begin w = DW'($urandom); out_q.push_back(w); exp_rx.push_back(w); end
            end
            if (tx_req) begin
                tx_req = 1'b0;
            end else if (!tx_busy && $urandom_range(0, 19) == 0) begin
                l  = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 40);
                lc = (l > PKT) ? PKT : l;
                for (int i = 0; i < 512; i++) ram[i] = DW'($urandom);
                for (int i = 0; i < lc; i++) exp_tx.push_back(ram[i]);
                if (lc < PKT) exp_pk++;
                exp_done++;
                tx_len = LW'(l); tx_req = 1'b1;
            end else if (tx_busy && $urandom_range(0, 31) == 0) begin
                tx_len = LW'($urandom); tx_req = 1'b1;
            end
        end
        @(negedge ifclk);
        tx_req = 1'b0; rx_hold = 1'b0; full_hold = 1'b0;
        n = 0;
        while ((out_q.size() != 0 || tx_busy || done_cnt < exp_done) && n < 5000) begin @(negedge ifclk); n++; end
        repeat (10) @(negedge ifclk);
        chk("rnd_rx_count", rx_got.size(), exp_rx.size());
        mism = 0;
        foreach (rx_got[i]) if (i < exp_rx.size() && rx_got[i].d !== exp_rx[i]) mism++;
        chk("rnd_rx_data", mism, 0);
        chk("rnd_rx_frame", frame_errs(nb), 0);
        chk("rnd_tx_count", in_cap.size(), exp_tx.size());
        mism = 0;
        foreach (in_cap[i]) if (i < exp_tx.size() && in_cap[i] !== exp_tx[i]) mism++;
        chk("rnd_tx_data", mism, 0);
        chk("rnd_pkend", pk_cnt, exp_pk);
        chk("rnd_done", done_cnt, exp_done);
        chk("rnd_stall_wr", stall_wr, 0);

        // Reset in the middle of an IN transfer
        clear_logs();
        issue_tx(200);
        n = 0;
        while (in_cap.size() < 50 && n < 500) begin @(negedge ifclk); n++; end
        chk("rstmid_started", int'(in_cap.size() >= 50), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_slwr", int'(slwr), 0);
        chk("rstmid_wen", int'(wen), 0);
        chk("rstmid_pkend", int'(pkend), 0);
        chk("rstmid_busy", int'(tx_busy), 0);
        repeat (2) @(negedge ifclk);
        rst_n = 1'b1;
        base = in_cap.size();
        repeat (30) @(negedge ifclk);
        chk("rstmid_no_resume", in_cap.size() - base, 0);
        chk("rstmid_busy_late", int'(tx_busy), 0);
        chk("rstmid_done", done_cnt, 0);

        chk("inv_sloe_wen", overlap, 0);
        chk("inv_fifoaddr", addr_bad, 0);
        chk("inv_underrun", underrun, 0);
        chk("nozlp_quiet", nz_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
